// File: rtl/cpu_pkg.sv
// Shared CPU datapath definitions: clear-engine states and default register file geometry.
package cpu_pkg;

   localparam int CPU_DATA_W = 8;
   localparam int CPU_NREG   = 16;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      CLEAR = 2'd1,
      DONE  = 2'd2
   } clr_state_e;

endpackage

// File: rtl/regfile_param.sv
// Parametrised two-read/one-write register file with optional zero register,
// write-to-read bypass and a sequenced clear engine.
//
//   state | meaning
//   IDLE  | normal operation, writes accepted, waiting for clr_req
//   CLEAR | zeroing one register per cycle at ptr, writes dropped
//   DONE  | clear finished, clr_done pulses, writes still dropped
module regfile_param
   import cpu_pkg::*;
#(
   parameter int DATA_W    = CPU_DATA_W,
   parameter int NREG      = CPU_NREG,
   parameter int ZERO_REG0 = 0,
   parameter int BYPASS    = 1,
   localparam int ADDR_W   = $clog2(NREG)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              we,
   input  logic [ADDR_W-1:0] dst,
   input  logic [DATA_W-1:0] wdata,
   input  logic [ADDR_W-1:0] src0,
   input  logic [ADDR_W-1:0] src1,
   output logic [DATA_W-1:0] data0,
   output logic [DATA_W-1:0] data1,
   input  logic              clr_req,
   output logic              clr_busy,
   output logic              clr_done,
   output logic              wr_drop,
   input  logic [ADDR_W-1:0] dbg_addr,
   output logic [DATA_W-1:0] dbg_data
);

   clr_state_e        state_q, state_d;
   logic [ADDR_W-1:0] ptr_q, ptr_d;
   logic              wr_drop_q, wr_drop_d;
   logic [DATA_W-1:0] mem_q [NREG];
   logic [DATA_W-1:0] mem_d [NREG];
   logic              wr_zero;
   logic              wr_acc;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      case (state_q)
         IDLE: begin
            ptr_d = '0;
            if (clr_req) state_d = CLEAR;
         end
         CLEAR: begin
            // ptr wraps back to 0 on the same edge that leaves CLEAR
            ptr_d = ptr_q + ADDR_W'(1);
            if (ptr_q == ADDR_W'(NREG - 1)) state_d = DONE;
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      clr_busy = 1'b0;
      clr_done = 1'b0;
      case (state_q)
         CLEAR:   clr_busy = 1'b1;
         DONE: begin
            clr_busy = 1'b1;
            clr_done = 1'b1;
         end
         default: clr_busy = 1'b0;
      endcase
   end

   always_comb begin
      wr_zero   = (ZERO_REG0 != 0) && (dst == '0);
      wr_acc    = we && !clr_busy && !wr_zero;
      wr_drop_d = we && clr_busy && !wr_zero;
   end

   always_comb begin
      mem_d = mem_q;
      if (state_q == CLEAR) begin
         mem_d[ptr_q] = '0;
      end else if (wr_acc) begin
         mem_d[dst] = wdata;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr_q     <= '0;
         wr_drop_q <= 1'b0;
         for (int i = 0; i < NREG; i++) mem_q[i] <= '0;
      end else begin
         ptr_q     <= ptr_d;
         wr_drop_q <= wr_drop_d;
         mem_q     <= mem_d;
      end
   end

   assign wr_drop = wr_drop_q;

   // wr_acc already excludes the protected register, so bypass never leaks into address 0
   always_comb begin
      data0 = mem_q[src0];
      if ((ZERO_REG0 != 0) && (src0 == '0)) begin
         data0 = '0;
      end else if ((BYPASS != 0) && wr_acc && (dst == src0)) begin
         data0 = wdata;
      end

      data1 = mem_q[src1];
      if ((ZERO_REG0 != 0) && (src1 == '0)) begin
         data1 = '0;
      end else if ((BYPASS != 0) && wr_acc && (dst == src1)) begin
         data1 = wdata;
      end

      dbg_data = mem_q[dbg_addr];
      if ((ZERO_REG0 != 0) && (dbg_addr == '0)) dbg_data = '0;
   end

endmodule
